// File: rtl/dmem_responder.sv
// dmem_responder: byte-masked word-array slave for the LSU data port; data_ready_o pulses WAIT_STATES+1 cycles
// after acceptance and requests are taken only in IDLE (one per WAIT_STATES+2 cycles). Optional: DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        data_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  // Lookahead for the access entering RESP: with zero wait states it comes straight from the inputs.
  logic          enter_resp;
  logic [31:0]   lk_addr;
  logic          lk_we;
  logic [AW-1:0] lk_idx;
  logic          lk_oor;
  logic [AW-1:0] wr_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    lk_addr    = addr_q;
    lk_we      = we_q;

    case (state_q)
      S_IDLE: begin
        if (data_req_i) begin
          we_d    = data_we_i;
          be_d    = data_be_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          lk_addr = data_addr_i;
          lk_we   = data_we_i;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    lk_idx = AW'((lk_addr - BASE_ADDR) >> 2);
`ifdef DMEM_RANGE_CHECK_EN
    lk_oor = ((lk_addr - BASE_ADDR) >= SPAN);
`else
    lk_oor = 1'b0;
`endif

    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = lk_oor;
      if (!lk_we) begin
        rdata_d = lk_oor ? 32'h0 : mem[lk_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Writes commit on the edge that ends RESP; err_q is high exactly when the access was out of range.
  assign wr_idx = AW'((addr_q - BASE_ADDR) >> 2);

  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_RESP && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign data_rdata_o = rdata_q;
  assign data_ready_o = ready_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign data_err_o   = err_q;
`else
  assign data_err_o   = 1'b0;
`endif

endmodule
